ddr_wr_arb: RTL and testbench
=============================

DDR_WR_ARB -- requirements
Module: ddr_wr_arb

Interface
REQ-001 Parameter BURST_LEN, default 16, SHALL set the data beats per granted burst (legal 1..256).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_a / req_b  input  1 each  write request: a = rectifier, b = block matcher.
REQ-005 ack_a / ack_b  output  1 each  one-cycle grant acknowledge to each requester.
REQ-006 dout_a / dout_b  input  32 each  requester write data.
REQ-007 strb_a / strb_b  input  4 each  requester byte strobes.
REQ-008 vout_a / vout_b  input  1 each  requester data-valid.
REQ-009 ddr_req  output  1  request to the DDR write port.
REQ-010 ddr_ack  input  1  one-cycle accept from the DDR write port.
REQ-011 ddr_dout  output  32  muxed write data.
REQ-012 ddr_strb  output  4  muxed byte strobes.
REQ-013 ddr_vout  output  1  muxed data-valid.
REQ-014 gnt  output  2  current owner, one-hot: bit0 = a, bit1 = b; 00 = none.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ and DATA.
REQ-017 IDLE:
- If any req_x is high, the FSM SHALL select one requester, set gnt, and move to REQ on the next cycle.
REQ-018 Selection SHALL be round-robin:
- If only one requester asks, it wins.
- If both ask in the same cycle, the requester not granted most recently wins.
- After reset, a wins a tie.
REQ-019 REQ state:
- ddr_req SHALL be held at 1.
- When ddr_ack=1 is sampled, ack_x of the granted requester SHALL be 1 for that same cycle (combinational pass of ddr_ack gated by gnt).
- The FSM SHALL then move to DATA.
REQ-020 ack_x of the non-granted requester SHALL never be 1.
REQ-021 The requester SHALL hold req_x high until it sees ack_x. A req_x drop during REQ is ignored: the arbiter keeps ddr_req high until ddr_ack.
REQ-022 DATA state:
- ddr_dout, ddr_strb and ddr_vout SHALL be registered copies of the granted requester's dout/strb/vout.
- Latency SHALL be exactly 1 clk.
REQ-023 vout, dout and strb of the non-granted requester SHALL be ignored in every state.
REQ-024 Beat counting:
- An 8-bit beat counter SHALL clear on entry to DATA and increment on each granted vout=1.
- The beat that makes the count equal BURST_LEN SHALL return the FSM to IDLE on the next edge.
- That final beat SHALL still appear on ddr_vout one cycle later.
REQ-025 Gaps (vout=0) inside a burst SHALL be allowed. Beats beyond BURST_LEN do not exist, because the FSM has already left DATA.
REQ-026 Outside DATA (plus the one trailing pipeline cycle), ddr_vout SHALL be 0, ddr_dout SHALL hold its last value, and ddr_strb SHALL hold its last value.
REQ-027 On the exit from DATA, gnt SHALL return to 00 and the round-robin pointer SHALL record the requester just served.
REQ-028 Back-to-back arbitration:
- A new arbitration MAY occur in the first IDLE cycle after DATA.
- This gives a minimum of 1 idle cycle between bursts.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 While rst=1, the block SHALL produce:
- state IDLE;
- ddr_req=0, ack_a=0, ack_b=0, ddr_vout=0;
- ddr_dout=32'h0, ddr_strb=4'h0, gnt=00, busy=0;
- beat counter 0;
- round-robin pointer set so that a wins the next tie.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately. No further ddr_vout is produced, and no state is retained.

Verification
REQ-032 Single requester:
- Stimulus: req_a=1; ddr_ack pulses 3 cycles later; BURST_LEN=16 beats with dout_a=0..15 and vout_a continuous.
- Response: gnt=01, ack_a pulses with ddr_ack, ddr_dout=0..15 each 1 cycle after input, busy falls after beat 16.
REQ-033 Simultaneous requests after reset:
- Stimulus: req_a=req_b=1.
- Response: a is served first; b is granted in the first IDLE cycle after a's burst; the next tie goes to a.
REQ-034 Gapped burst:
- Stimulus: vout_a toggles 1,0,1,0...
- Response: exactly 16 ddr_vout beats; FSM exits only after the 16th valid beat.
REQ-035 Isolation:
- Stimulus: during a's burst, vout_b=1 with dout_b=32'hDEADBEEF.
- Response: ddr_dout never equals DEADBEEF; ack_b stays 0.
REQ-036 Reset mid-burst:
- Stimulus: rst=1 at beat 8 for 1 cycle.
- Response: the next cycle shows ddr_vout=0, gnt=00, busy=0; a following req_b is granted normally with a full 16 beats.
REQ-037 BURST_LEN=1:
- Stimulus: one vout beat.
- Response: IDLE is reached on the next edge; ddr_vout=1 for exactly one cycle.

Source files
------------

// File: rtl/ddr_wr_arb.sv
// Two-requester round-robin write arbiter in front of a single DDR write port.
// Grants one full burst of BURST_LEN beats and forwards the owner's data one cycle later.
module ddr_wr_arb #(
    parameter int BURST_LEN = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    output logic              ack_a,
    output logic              ack_b,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    input  logic [3:0]        strb_a,
    input  logic [3:0]        strb_b,
    input  logic              vout_a,
    input  logic              vout_b,
    output logic              ddr_req,
    input  logic              ddr_ack,
    output logic [DATA_W-1:0] ddr_dout,
    output logic [3:0]        ddr_strb,
    output logic              ddr_vout,
    output logic [1:0]        gnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [8:0] LP_BURST = 9'(BURST_LEN);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_gnt;
    logic [1:0]          w_gnt_nxt;
    logic                r_last_b;
    logic                w_last_b_nxt;
    logic [7:0]          r_beat;
    logic [7:0]          w_beat_nxt;
    logic                w_sel_vout;
    logic [DATA_W-1:0]   w_sel_dout;
    logic [3:0]          w_sel_strb;
    logic                w_last_beat;
    logic                r_vld_p1;
    logic [DATA_W-1:0]   r_dout_p1;
    logic [3:0]          r_strb_p1;

    // Only the owner's lanes are looked at; the other requester is fully masked.
    assign w_sel_vout  = (r_gnt[0] & vout_a) | (r_gnt[1] & vout_b);
    assign w_sel_dout  = r_gnt[1] ? dout_b : dout_a;
    assign w_sel_strb  = r_gnt[1] ? strb_b : strb_a;
    assign w_last_beat = ({1'b0, r_beat} + 9'd1) == LP_BURST;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_last_b_nxt = r_last_b;
        w_beat_nxt   = r_beat;
        case (r_state)
            IDLE: begin
                // r_last_b=1 means b was served last, so a wins a tie.
                if (req_a && (!req_b || r_last_b)) begin
                    w_gnt_nxt   = 2'b01;
                    w_state_nxt = REQ;
                end else if (req_b) begin
                    w_gnt_nxt   = 2'b10;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (ddr_ack) begin
                    w_beat_nxt  = 8'd0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_sel_vout) begin
                    w_beat_nxt = r_beat + 8'd1;
                    if (w_last_beat) begin
                        w_state_nxt  = IDLE;
                        w_gnt_nxt    = 2'b00;
                        w_last_b_nxt = r_gnt[1];
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= 2'b00;
            r_last_b <= 1'b1;
            r_beat   <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_last_b <= w_last_b_nxt;
            r_beat   <= w_beat_nxt;
        end
    end

    // Stage p1: one-cycle registered copy of the owner's write lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_dout_p1 <= '0;
            r_strb_p1 <= 4'h0;
        end else begin
            r_vld_p1 <= (r_state == DATA) && w_sel_vout;
            if (r_state == DATA) begin
                r_dout_p1 <= w_sel_dout;
                r_strb_p1 <= w_sel_strb;
            end
        end
    end

    assign ack_a    = (r_state == REQ) & ddr_ack & r_gnt[0];
    assign ack_b    = (r_state == REQ) & ddr_ack & r_gnt[1];
    assign ddr_req  = (r_state == REQ);
    assign ddr_dout = r_dout_p1;
    assign ddr_strb = r_strb_p1;
    assign ddr_vout = r_vld_p1;
    assign gnt      = r_gnt;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Directed bench for ddr_wr_arb: default BURST_LEN=16 instance plus a BURST_LEN=1 instance.
module tb_ddr_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, ack_a, ack_b;
    logic [31:0] dout_a, dout_b, ddr_dout;
    logic [3:0]  strb_a, strb_b, ddr_strb;
    logic        vout_a, vout_b, ddr_req, ddr_ack, ddr_vout, busy;
    logic [1:0]  gnt;

    logic        req_a1, req_b1, ack_a1, ack_b1;
    logic [31:0] dout_a1, dout_b1, ddr_dout1;
    logic [3:0]  strb_a1, strb_b1, ddr_strb1;
    logic        vout_a1, vout_b1, ddr_req1, ddr_ack1, ddr_vout1, busy1;
    logic [1:0]  gnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr_wr_arb u_dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .ack_a(ack_a), .ack_b(ack_b),
        .dout_a(dout_a), .dout_b(dout_b), .strb_a(strb_a), .strb_b(strb_b),
        .vout_a(vout_a), .vout_b(vout_b),
        .ddr_req(ddr_req), .ddr_ack(ddr_ack),
        .ddr_dout(ddr_dout), .ddr_strb(ddr_strb), .ddr_vout(ddr_vout),
        .gnt(gnt), .busy(busy)
    );

    ddr_wr_arb #(.BURST_LEN(1)) u_one (
        .clk(clk), .rst(rst),
        .req_a(req_a1), .req_b(req_b1), .ack_a(ack_a1), .ack_b(ack_b1),
        .dout_a(dout_a1), .dout_b(dout_b1), .strb_a(strb_a1), .strb_b(strb_b1),
        .vout_a(vout_a1), .vout_b(vout_b1),
        .ddr_req(ddr_req1), .ddr_ack(ddr_ack1),
        .ddr_dout(ddr_dout1), .ddr_strb(ddr_strb1), .ddr_vout(ddr_vout1),
        .gnt(gnt1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs a 16-beat burst for the owner (use_b selects b); the other requester
    // drives DEADBEEF with vout=1 throughout. ddr_ack is held high to show it
    // cannot produce acks outside REQ.
    task automatic run_burst(input bit use_b, input logic [31:0] base, input bit gap);
        int beats = 0;
        int cyc   = 0;
        logic v;
        logic [3:0] s;
        ddr_ack = 1'b1;
        while (beats < 16 && cyc < 100) begin
            v = gap ? (cyc % 2 == 0) : 1'b1;
            s = beats[3:0];
            if (use_b) begin
                vout_b = v; dout_b = base + beats; strb_b = s;
                vout_a = 1'b1; dout_a = 32'hDEADBEEF; strb_a = 4'h0;
            end else begin
                vout_a = v; dout_a = base + beats; strb_a = s;
                vout_b = 1'b1; dout_b = 32'hDEADBEEF; strb_b = 4'h0;
            end
            tick();
            chk("ddr_vout", {31'd0, ddr_vout}, {31'd0, v});
            if (v) begin
                chk("ddr_dout", ddr_dout, base + beats);
                chk("ddr_strb", {28'd0, ddr_strb}, {28'd0, s});
                beats++;
            end
            chk("busy", {31'd0, busy}, {31'd0, beats < 16});
            chk("gnt", {30'd0, gnt}, (beats < 16) ? (use_b ? 32'd2 : 32'd1) : 32'd0);
            chk("ack_a_in_data", {31'd0, ack_a}, 32'd0);
            chk("ack_b_in_data", {31'd0, ack_b}, 32'd0);
            cyc++;
        end
        chk("burst_beats", beats, 16);
        ddr_ack = 1'b0;
        vout_a = 1'b0; vout_b = 1'b0;
        dout_a = 32'h12345678; dout_b = 32'h12345678;
        strb_a = 4'hA; strb_b = 4'hA;
        tick();
        chk("trail_vout", {31'd0, ddr_vout}, 32'd0);
        chk("hold_dout", ddr_dout, base + 32'd15);
        chk("hold_strb", {28'd0, ddr_strb}, 32'hF);
    endtask

    initial begin
        rst = 1'b1;
        req_a = 0; req_b = 0; ddr_ack = 0;
        dout_a = 0; dout_b = 0; strb_a = 0; strb_b = 0; vout_a = 0; vout_b = 0;
        req_a1 = 0; req_b1 = 0; ddr_ack1 = 0;
        dout_a1 = 0; dout_b1 = 0; strb_a1 = 0; strb_b1 = 0; vout_a1 = 0; vout_b1 = 0;
        tick();
        tick();
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ddr_req", {31'd0, ddr_req}, 32'd0);
        chk("rst_vout", {31'd0, ddr_vout}, 32'd0);
        chk("rst_dout", ddr_dout, 32'd0);
        chk("rst_strb", {28'd0, ddr_strb}, 32'd0);
        chk("rst_acks", {30'd0, ack_b, ack_a}, 32'd0);

        // Single requester, ddr_ack three cycles after the grant
        rst = 1'b0;
        req_a = 1'b1;
        tick();
        chk("s_gnt", {30'd0, gnt}, 32'd1);
        chk("s_busy", {31'd0, busy}, 32'd1);
        chk("s_ddr_req", {31'd0, ddr_req}, 32'd1);
        chk("s_ack_a_wait", {31'd0, ack_a}, 32'd0);
        tick();
        tick();
        chk("s_ddr_req_held", {31'd0, ddr_req}, 32'd1);
        ddr_ack = 1'b1;
        #1;
        chk("s_ack_a", {31'd0, ack_a}, 32'd1);
        chk("s_ack_b", {31'd0, ack_b}, 32'd0);
        tick();
        ddr_ack = 1'b0;
        req_a = 1'b0;
        chk("s_ddr_req_drop", {31'd0, ddr_req}, 32'd0);
        run_burst(1'b0, 32'd0, 1'b0);
        chk("s_idle_gnt", {30'd0, gnt}, 32'd0);

        // Tie after reset: a first, then b, then the next tie goes to a
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        tick();
        chk("t1_gnt", {30'd0, gnt}, 32'd1);
        ddr_ack = 1'b1;
        #1;
        chk("t1_ack_a", {31'd0, ack_a}, 32'd1);
        chk("t1_ack_b", {31'd0, ack_b}, 32'd0);
        tick();
        req_a = 1'b0;
        run_burst(1'b0, 32'h100, 1'b0);
        chk("t2_gnt", {30'd0, gnt}, 32'd2);
        ddr_ack = 1'b1;
        #1;
        chk("t2_ack_b", {31'd0, ack_b}, 32'd1);
        chk("t2_ack_a", {31'd0, ack_a}, 32'd0);
        tick();
        req_a = 1'b1;
        run_burst(1'b1, 32'h200, 1'b0);
        chk("t3_gnt", {30'd0, gnt}, 32'd1);
        ddr_ack = 1'b1;
        #1;
        chk("t3_ack_a", {31'd0, ack_a}, 32'd1);
        tick();
        req_a = 1'b0;

        // Gapped burst on a; b still waiting and granted afterwards
        run_burst(1'b0, 32'h300, 1'b1);
        chk("g_next_gnt", {30'd0, gnt}, 32'd2);
        ddr_ack = 1'b1;
        tick();
        ddr_ack = 1'b0;
        req_b = 1'b0;

        // Reset at beat 8 of b's burst
        for (int i = 0; i < 8; i++) begin
            vout_b = 1'b1;
            dout_b = 32'h400 + i;
            strb_b = 4'h3;
            if (i == 7) rst = 1'b1;
            tick();
            if (i < 7) chk("r_dout", ddr_dout, 32'h400 + i);
        end
        chk("r_vout", {31'd0, ddr_vout}, 32'd0);
        chk("r_gnt", {30'd0, gnt}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_dout_clr", ddr_dout, 32'd0);
        rst = 1'b0;
        vout_b = 1'b0;
        tick();
        chk("r_idle_vout", {31'd0, ddr_vout}, 32'd0);
        req_b = 1'b1;
        tick();
        chk("r2_gnt", {30'd0, gnt}, 32'd2);
        ddr_ack = 1'b1;
        #1;
        chk("r2_ack_b", {31'd0, ack_b}, 32'd1);
        tick();
        req_b = 1'b0;
        run_burst(1'b1, 32'h500, 1'b0);
        chk("r2_busy", {31'd0, busy}, 32'd0);

        // BURST_LEN=1 instance
        req_a1 = 1'b1;
        tick();
        chk("b1_gnt", {30'd0, gnt1}, 32'd1);
        ddr_ack1 = 1'b1;
        #1;
        chk("b1_ack_a", {31'd0, ack_a1}, 32'd1);
        tick();
        ddr_ack1 = 1'b0;
        req_a1 = 1'b0;
        chk("b1_busy_data", {31'd0, busy1}, 32'd1);
        vout_a1 = 1'b1;
        dout_a1 = 32'hCAFE0001;
        strb_a1 = 4'h5;
        tick();
        chk("b1_busy_exit", {31'd0, busy1}, 32'd0);
        chk("b1_gnt_exit", {30'd0, gnt1}, 32'd0);
        chk("b1_vout", {31'd0, ddr_vout1}, 32'd1);
        chk("b1_dout", ddr_dout1, 32'hCAFE0001);
        vout_a1 = 1'b0;
        tick();
        chk("b1_vout_end", {31'd0, ddr_vout1}, 32'd0);
        chk("b1_busy_end", {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
